// File: rtl/board_ctl.sv
// GRID x GRID tic-tac-toe board controller.
// Hit-tests clicks, enforces turn order, sends local moves and checks remote moves.
module board_ctl #(
   parameter int GRID   = 3,
   parameter int CELL_W = 339,
   parameter int CELL_H = 252,
   parameter int GAP    = 6,
   parameter int X0     = 0,
   parameter int Y0     = 0,
   localparam int N     = GRID * GRID,
   localparam int CW    = $clog2(N + 1)
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          game_en,
   input  logic          playerID,
   input  logic          mouse_left,
   input  logic [11:0]   xpos,
   input  logic [11:0]   ypos,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   input  logic          tx_ready,
   output logic          tx_valid,
   output logic [7:0]    tx_data,
   output logic [N-1:0]  occupied,
   output logic [N-1:0]  owner,
   output logic [CW-1:0] move_cnt,
   output logic          my_turn,
   output logic          board_full,
   output logic          rx_err
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      IDLE, LOCAL, TX_WAIT, REMOTE, DONE
   } state_t;

   state_t        state;
   logic          en_q;
   logic          en_rise;
   logic          mouse_q;
   logic          click_q;
   logic [IW-1:0] idx_q;
   logic [7:0]    pos_q;

   logic          hit_x, hit_y;
   logic [3:0]    col_c, row_c;
   logic [3:0]    rx_row, rx_col;
   logic [IW-1:0] rx_idx;
   logic          rx_ok;

   assign en_rise    = game_en & ~en_q;
   assign board_full = (move_cnt == CW'(N));
   assign my_turn    = (state == LOCAL);
   assign rx_row     = rx_data[7:4];
   assign rx_col     = rx_data[3:0];
   assign rx_idx     = IW'(int'(rx_row) * GRID + int'(rx_col));

   // Pixel hit test; gaps and out-of-grid positions leave hit low.
   always_comb begin
      hit_x = 1'b0;
      hit_y = 1'b0;
      col_c = '0;
      row_c = '0;
      for (int c = 0; c < GRID; c++) begin
         if (int'(xpos) >= X0 + c * (CELL_W + GAP) &&
             int'(xpos) <= X0 + c * (CELL_W + GAP) + CELL_W - 1) begin
            hit_x = 1'b1;
            col_c = 4'(c);
         end
         if (int'(ypos) >= Y0 + c * (CELL_H + GAP) &&
             int'(ypos) <= Y0 + c * (CELL_H + GAP) + CELL_H - 1) begin
            hit_y = 1'b1;
            row_c = 4'(c);
         end
      end
   end

   always_comb begin
      rx_ok = 1'b0;
      if (int'(rx_row) < GRID && int'(rx_col) < GRID) begin
         rx_ok = ~occupied[rx_idx];
      end
   end

   // Click edge detect plus registered hit result.
   always_ff @(posedge pclk) begin
      if (rst) begin
         mouse_q <= 1'b0;
         click_q <= 1'b0;
         idx_q   <= '0;
         pos_q   <= '0;
      end else begin
         mouse_q <= mouse_left;
         click_q <= mouse_left & ~mouse_q & hit_x & hit_y;
         idx_q   <= IW'(int'(row_c) * GRID + int'(col_c));
         pos_q   <= {row_c, col_c};
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state    <= IDLE;
         en_q     <= 1'b0;
         occupied <= '0;
         owner    <= '0;
         move_cnt <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         rx_err   <= 1'b0;
      end else begin
         en_q   <= game_en;
         rx_err <= 1'b0;
         if (!game_en) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
         end else begin
            unique case (state)
               IDLE, DONE: begin
                  if (state == DONE && rx_valid)
                     rx_err <= 1'b1;
                  if (en_rise) begin
                     occupied <= '0;
                     owner    <= '0;
                     move_cnt <= '0;
                     state    <= playerID ? REMOTE : LOCAL;
                  end
               end
               LOCAL: begin
                  if (rx_valid)
                     rx_err <= 1'b1;
                  if (click_q && !occupied[idx_q]) begin
                     occupied[idx_q] <= 1'b1;
                     owner[idx_q]    <= playerID;
                     move_cnt        <= move_cnt + CW'(1);
                     tx_data         <= pos_q;
                     tx_valid        <= 1'b1;
                     state           <= TX_WAIT;
                  end
               end
               TX_WAIT: begin
                  if (rx_valid)
                     rx_err <= 1'b1;
                  if (tx_ready) begin
                     tx_valid <= 1'b0;
                     state    <= board_full ? DONE : REMOTE;
                  end
               end
               REMOTE: begin
                  if (rx_valid) begin
                     if (rx_ok) begin
                        occupied[rx_idx] <= 1'b1;
                        owner[rx_idx]    <= ~playerID;
                        move_cnt         <= move_cnt + CW'(1);
                        state <= (move_cnt == CW'(N - 1)) ? DONE : LOCAL;
                     end else begin
                        rx_err <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
